// File: rtl/pid_pwm_driver.sv
// Paces pid iterations, accumulates corrections into a saturating signed command and
// drives sign/magnitude PWM. Define DIR_DEADTIME_EN to blank PWM for one period on direction change.
module pid_pwm_driver #(
  parameter int D_WIDTH    = 16,
  parameter int PWM_BITS   = 10,
  parameter int PERIOD_DIV = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic signed [D_WIDTH-1:0] pid_out,
  input  logic                      pid_out_valid,
  output logic                      iterate_enable,
  output logic signed [D_WIDTH-1:0] command,
  output logic                      pwm,
  output logic                      dir,
  output logic                      fault
);

  localparam int DIV_W = (PERIOD_DIV > 1) ? $clog2(PERIOD_DIV) : 1;
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PERIOD_DIV - 1);
  localparam logic signed [D_WIDTH:0] SAT_HI = (D_WIDTH+1)'((2 ** (D_WIDTH-1)) - 1);
  localparam logic signed [D_WIDTH:0] SAT_LO = -SAT_HI;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t                     state_q;
  logic                       iterate_q;
  logic [PWM_BITS-1:0]        toCnt_q;
  logic signed [D_WIDTH-1:0]  command_q;
  logic                       fault_q;

  logic [PWM_BITS-1:0]        pwmCnt_q, pwmCnt_d;
  logic [DIV_W-1:0]           divCnt_q, divCnt_d;
  logic                       boundary;
  logic                       lastDiv;

  logic signed [D_WIDTH:0]    sumExt;
  logic signed [D_WIDTH-1:0]  satCmd;

  logic [D_WIDTH-1:0]         absCmd;
  logic [PWM_BITS-1:0]        dutyTarget;
  logic [PWM_BITS-1:0]        duty_q;
  logic                       dir_q;
  logic                       pwm_q;
  logic                       blank;
  logic                       unusedAbs;

  // The wrap cycle of the PWM counter is the period boundary; everything paces off it.
  always_comb begin
    boundary = enable && (pwmCnt_q == PWM_MAX);
    lastDiv  = (divCnt_q == DIV_LAST);
    pwmCnt_d = enable ? pwmCnt_q + 1'b1 : '0;
    divCnt_d = divCnt_q;
    if (!enable) begin
      divCnt_d = '0;
    end else if (boundary) begin
      divCnt_d = lastDiv ? '0 : divCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwmCnt_q <= '0;
      divCnt_q <= '0;
    end else begin
      pwmCnt_q <= pwmCnt_d;
      divCnt_q <= divCnt_d;
    end
  end

  // One extra bit of headroom, then clamp symmetrically so the most-negative code never appears.
  always_comb begin
    sumExt = {command_q[D_WIDTH-1], command_q} + {pid_out[D_WIDTH-1], pid_out};
    if (sumExt > SAT_HI) begin
      satCmd = SAT_HI[D_WIDTH-1:0];
    end else if (sumExt < SAT_LO) begin
      satCmd = SAT_LO[D_WIDTH-1:0];
    end else begin
      satCmd = sumExt[D_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      iterate_q <= 1'b0;
      toCnt_q   <= '0;
      command_q <= '0;
      fault_q   <= 1'b0;
    end else if (!enable) begin
      state_q   <= ST_IDLE;
      iterate_q <= 1'b0;
      toCnt_q   <= '0;
    end else begin
      iterate_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (boundary && lastDiv) begin
            state_q   <= ST_REQ;
            iterate_q <= 1'b1;
          end
        end
        ST_REQ: begin
          state_q <= ST_WAIT;
          toCnt_q <= '0;
        end
        ST_WAIT: begin
          if (pid_out_valid) begin
            command_q <= satCmd;
            state_q   <= ST_IDLE;
          end else if (toCnt_q == PWM_MAX) begin
            fault_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            toCnt_q <= toCnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    absCmd = command_q[D_WIDTH-1] ? D_WIDTH'(-command_q) : command_q;
  end

  // Magnitude bit just below the sign down to PWM_BITS bits: full-scale maps to 2^PWM_BITS-1.
  assign dutyTarget = absCmd[D_WIDTH-2 -: PWM_BITS];
  assign unusedAbs  = ^absCmd;

`ifdef DIR_DEADTIME_EN
  logic blank_q;

  // A sign change at a boundary blanks the following period; another flip re-arms it.
  always_ff @(posedge clk) begin
    if (rst) begin
      blank_q <= 1'b0;
    end else if (boundary) begin
      blank_q <= (command_q[D_WIDTH-1] != dir_q);
    end
  end

  assign blank = blank_q;
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q <= '0;
      dir_q  <= 1'b0;
      pwm_q  <= 1'b0;
    end else begin
      if (boundary) begin
        duty_q <= dutyTarget;
        dir_q  <= command_q[D_WIDTH-1];
      end
      pwm_q <= enable && !blank && (pwmCnt_q < duty_q);
    end
  end

  assign iterate_enable = iterate_q;
  assign command        = command_q;
  assign pwm            = pwm_q;
  assign dir            = dir_q;
  assign fault          = fault_q;

endmodule

// File: tb/tb_pid_pwm_driver.sv
// Self-checking bench for pid_pwm_driver: pacing, saturating accumulate, PWM duty/dir,
// timeout fault, reset abort and enable gating.
module tb_pid_pwm_driver;

  localparam int DW     = 16;
  localparam int PB     = 10;
  localparam int PD     = 4;
  localparam int PERIOD = 1 << PB;
  localparam int NV     = 11;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable;
  logic signed [DW-1:0] pid_out;
  logic                 pid_out_valid;
  logic                 iterate_enable;
  logic signed [DW-1:0] command;
  logic                 pwm;
  logic                 dir;
  logic                 fault;

  always #5 clk = ~clk;

  pid_pwm_driver #(.D_WIDTH(DW), .PWM_BITS(PB), .PERIOD_DIV(PD)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .pid_out(pid_out),
    .pid_out_valid(pid_out_valid),
    .iterate_enable(iterate_enable),
    .command(command),
    .pwm(pwm),
    .dir(dir),
    .fault(fault)
  );

  typedef struct {
    logic signed [DW-1:0] pidIn;
    logic signed [DW-1:0] expCmd;
    int                   expDuty;
    bit                   expDir;
  } vec_t;

  vec_t                 vecs[NV];
  logic signed [DW-1:0] expQ[$];
  int                   checkCount = 0;
  int                   passCount  = 0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitRequest(input int limit, output int n, output int pwmHigh);
    n = 0;
    pwmHigh = 0;
    do begin
      tick();
      n++;
      pwmHigh += int'(pwm);
    end while (!iterate_enable && n < limit);
    if (!iterate_enable) checkOutput("request_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input logic signed [DW-1:0] v, input int delay,
                               input logic signed [DW-1:0] expected);
    repeat (delay) tick();
    pid_out       = v;
    pid_out_valid = 1'b1;
    expQ.push_back(expected);
    tick();
    pid_out_valid = 1'b0;
    pid_out       = '0;
  endtask

  task automatic checkCommand(input string name);
    logic signed [DW-1:0] e;
    if (expQ.size() == 0) begin
      checkOutput({name, "_scoreboard_empty"}, 0, 1);
    end else begin
      e = expQ.pop_front();
      checkOutput(name, command, e);
    end
  endtask

  initial begin
    int  n, ph, offset, highA, highB, d, expA;
    bit  prevDir;

    vecs[0]  = '{16'sd16384,  16'sd16384,  512,  1'b0};
    vecs[1]  = '{16'sd30000,  16'sd32767,  1023, 1'b0};
    vecs[2]  = '{16'sd30000,  16'sd32767,  1023, 1'b0};
    vecs[3]  = '{-16'sd32767, 16'sd0,      0,    1'b0};
    vecs[4]  = '{-16'sd32767, -16'sd32767, 1023, 1'b1};
    vecs[5]  = '{-16'sd32767, -16'sd32767, 1023, 1'b1};
    vecs[6]  = '{16'sd100,    -16'sd32667, 1020, 1'b1};
    vecs[7]  = '{16'h8000,    -16'sd32767, 1023, 1'b1};
    vecs[8]  = '{16'sd32767,  16'sd0,      0,    1'b0};
    vecs[9]  = '{16'sd8192,   16'sd8192,   256,  1'b0};
    vecs[10] = '{-16'sd16384, -16'sd8192,  256,  1'b1};

    rst = 1'b1;
    enable = 1'b0;
    pid_out = '0;
    pid_out_valid = 1'b0;
    repeat (3) tick();
    checkOutput("reset_iterate", iterate_enable, 0);
    checkOutput("reset_command", command, 0);
    checkOutput("reset_pwm", pwm, 0);
    checkOutput("reset_dir", dir, 0);
    checkOutput("reset_fault", fault, 0);
    rst = 1'b0;
    tick();

    // First request after PERIOD_DIV full periods
    enable = 1'b1;
    waitRequest(2 * PD * PERIOD, n, ph);
    checkOutput("first_request_cycle", n, PD * PERIOD);
    checkOutput("first_pwm_high_cycles", ph, 0);
    checkOutput("first_dir", dir, 0);

    prevDir = 1'b0;
    for (int i = 0; i < NV; i++) begin
      if (i > 0) begin
        waitRequest(2 * PERIOD, n, ph);
        checkOutput($sformatf("row%0d_request_gap", i), n, PERIOD);
      end
      tick();
      checkOutput($sformatf("row%0d_iterate_width", i), iterate_enable, 0);
      d = 1 + (i % 3);
      applyStimulus(vecs[i].pidIn, d, vecs[i].expCmd);
      offset = 2 + d;
      checkCommand($sformatf("row%0d_command", i));
      while (offset < PERIOD) begin
        tick();
        offset++;
      end
      highA = 0;
      highB = 0;
      for (int k = 0; k < PERIOD; k++) begin
        tick();
        if (k == 0) checkOutput($sformatf("row%0d_dir", i), dir, vecs[i].expDir);
        highA += int'(pwm);
      end
      for (int k = 0; k < PERIOD; k++) begin
        tick();
        highB += int'(pwm);
      end
`ifdef DIR_DEADTIME_EN
      expA = (vecs[i].expDir != prevDir) ? 0 : vecs[i].expDuty;
`else
      expA = vecs[i].expDuty;
`endif
      checkOutput($sformatf("row%0d_pwm_high_first_period", i), highA, expA);
      checkOutput($sformatf("row%0d_pwm_high_second_period", i), highB, vecs[i].expDuty);
      prevDir = vecs[i].expDir;
    end

    // No response: fault exactly PERIOD cycles after entering WAIT
    waitRequest(2 * PERIOD, n, ph);
    checkOutput("timeout_request_gap", n, PERIOD);
    offset = 0;
    while (offset < PERIOD) begin
      tick();
      offset++;
    end
    checkOutput("fault_not_early", fault, 0);
    tick();
    checkOutput("fault_set", fault, 1);
    checkOutput("timeout_command_held", command, -8192);
    waitRequest(2 * PD * PERIOD, n, ph);
    checkOutput("request_after_timeout", n, PD * PERIOD - PERIOD - 1);
    checkOutput("fault_sticky", fault, 1);

    // Reset while waiting, then a late response must be ignored
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    checkOutput("wait_reset_command", command, 0);
    checkOutput("wait_reset_fault", fault, 0);
    checkOutput("wait_reset_iterate", iterate_enable, 0);
    applyStimulus(16'sd5000, 1, 16'sd0);
    checkCommand("late_response_ignored");
    waitRequest(2 * PD * PERIOD, n, ph);
    checkOutput("request_after_reset", n, PD * PERIOD - 2);

    // Enable drop mid-period
    applyStimulus(16'sd16384, 2, 16'sd16384);
    offset = 3;
    checkCommand("enable_test_command");
    while (offset < PERIOD + 6) begin
      tick();
      offset++;
    end
    checkOutput("pwm_high_before_disable", pwm, 1);
    enable = 1'b0;
    tick();
    checkOutput("pwm_off_after_disable", pwm, 0);
    ph = 0;
    repeat (20) begin
      tick();
      ph += int'(pwm);
    end
    checkOutput("pwm_idle_high_cycles", ph, 0);
    checkOutput("disable_command_held", command, 16384);
    enable = 1'b1;
    waitRequest(2 * PD * PERIOD, n, ph);
    checkOutput("request_after_reenable", n, PD * PERIOD);
    checkOutput("reenable_fault", fault, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pid_pwm_driver.md
Name: pid_pwm_driver

Overview:
Downstream stage of the pid block. It paces the control loop by pulsing iterate_enable once every PERIOD_DIV PWM periods. It accumulates each pid correction (out/out_valid) into a saturating signed command. It converts that command to a sign/magnitude PWM drive with a direction output, updating duty only on PWM period boundaries.

Parameters:
D_WIDTH, 16, width of the pid output and of the command accumulator (signed)
PWM_BITS, 10, PWM counter width; PWM period = 2^PWM_BITS clk cycles; must be < D_WIDTH
PERIOD_DIV, 4, PWM periods per control iteration (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
enable  in  1  run control; low = idle, PWM forced off
pid_out  in  D_WIDTH  signed correction from pid out
pid_out_valid  in  1  pid out_valid
iterate_enable  out  1  one-cycle request to pid iterate_enable
command  out  D_WIDTH  signed accumulated command
pwm  out  1  PWM drive
dir  out  1  1 = negative command
fault  out  1  sticky: pid response timeout

Behaviour:
- Reset, synchronous active-high: command=0, duty=0, dir=0, pwm=0, iterate_enable=0, fault=0; pwm_cnt=0, div_cnt=0; FSM=IDLE. Reset mid-operation aborts any pending request; a pid response arriving after reset is ignored.
- pwm_cnt free-runs 0..2^PWM_BITS-1 and wraps while enable=1. Wrap cycle (pwm_cnt==max) = period boundary. div_cnt counts boundaries 0..PERIOD_DIV-1.
- enable=0: pwm_cnt, div_cnt held at 0; FSM forced IDLE; pwm=0; command, dir and fault held.
- FSM states IDLE, REQ, WAIT:
  - IDLE->REQ on a period boundary with div_cnt==PERIOD_DIV-1.
  - REQ: iterate_enable=1 for exactly this one cycle; ->WAIT.
  - WAIT: timeout counter starts at 0.
    - pid_out_valid=1: command <= sat(command + pid_out); ->IDLE.
    - Timeout counter reaches 2^PWM_BITS cycles without valid: fault<=1; command unchanged; ->IDLE.
  - pid_out_valid outside WAIT is ignored.
- Saturation: sum computed in D_WIDTH+1 bits; clamp to [-(2^(D_WIDTH-1)-1), +(2^(D_WIDTH-1)-1)]. Range is symmetric, so the most-negative code never occurs.
- Duty update at each period boundary only, so there are no mid-period glitches:
  - duty <= |command| >> (D_WIDTH-1-PWM_BITS)
  - dir <= command<0
- An accumulate on the boundary cycle is not visible until the next boundary.
- pwm is registered: pwm = (pwm_cnt < duty). duty=0 gives constant 0. Maximum duty is 2^PWM_BITS-1 (high all but one cycle).
- fault clears only on rst.

Optional Feature:
DIR_DEADTIME_EN:
- Defined: when a boundary update changes dir, the new dir is applied but pwm is forced 0 for the whole following period (duty treated as 0). The new duty takes effect at the boundary after that. A further sign flip during the blanking period extends the blanking by one more period.
- Undefined: dir and duty switch together at the boundary with no blanking.

Test Plan:
1. Reset then enable=1, PERIOD_DIV=4, PWM_BITS=10 -> first iterate_enable pulse at cycle 4*1024-1+1 after enable, one cycle wide; pwm=0, dir=0 throughout.
2. Respond pid_out=16384 3 cycles after request -> command=16384; at next boundary duty=512, pwm high 512 of 1024 cycles, dir=0.
3. Accumulate 30000 then 30000 -> command=32767 (clamped); then -32767 twice -> command=-32767, duty=1023, dir=1.
4. Never assert pid_out_valid -> fault=1 exactly 1024 cycles after entering WAIT; command unchanged; the next iterate_enable still issues at the following PERIOD_DIV boundary.
5. Assert rst while in WAIT, then pulse pid_out_valid -> command stays 0, no accumulate, FSM IDLE; enable low mid-period -> pwm=0 next cycle and pwm_cnt=0.
6. With DIR_DEADTIME_EN: command +8192 -> -8192 -> dir=1 at boundary, pwm=0 for 1024 cycles, then duty=256 at the following boundary; without the macro, duty=256 applies immediately.
